// File: rtl/c_drain_requant_seq_pkg.sv
// Shared types and constants for the C-buffer drain/requant sequencer.
// States, int32 limits and the CFU command ids that start and configure it.
package c_drain_requant_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } state_t;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  localparam logic [6:0] FID_DRAIN_START = 7'd40;
  localparam logic [6:0] FID_DRAIN_QCFG  = 7'd41;
  localparam logic [6:0] FID_DRAIN_CLAMP = 7'd42;

endpackage

// File: rtl/c_drain_requant_seq_requant_lane.sv
// One int32 -> int8 requant lane: bias add, Q31 multiply,
// then rounding shift, offset and clamp feeding the output FIFO.
module requant_lane
  import c_drain_requant_seq_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] i_lane,
  input  logic [31:0] i_bias,
  input  logic [31:0] i_mult,
  input  logic [4:0]  i_shift,
  input  logic [31:0] i_off,
  input  logic [7:0]  i_amin,
  input  logic [7:0]  i_amax,
  output logic [7:0]  o_q
);

  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
  localparam logic signed [63:0] TRUNC_ADJ = 64'sd2147483647;

  logic signed [31:0] r_acc;
  logic signed [63:0] r_p;
  logic               r_sat;

  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_s;
  logic signed [63:0] w_t;
  logic signed [31:0] w_x;
  logic signed [31:0] w_sh;
  logic [31:0]        w_mask;
  logic [31:0]        w_r;
  logic [31:0]        w_th;
  logic [31:0]        w_y;
  logic signed [32:0] w_z;
  logic signed [32:0] w_lo;
  logic signed [32:0] w_hi;

  assign w_a = r_acc;
  assign w_b = $signed(i_mult);

  always_ff @(posedge clk) begin
    r_acc <= i_lane + i_bias;
    r_p   <= w_a * w_b;
    r_sat <= (r_acc == INT32_MIN) && (i_mult == INT32_MIN);
  end

  // Negative sums get a bias so the shift truncates toward zero.
  always_comb begin
    w_s    = r_p + (r_p[63] ? NUDGE_NEG : NUDGE_POS);
    w_t    = w_s[63] ? w_s + TRUNC_ADJ : w_s;
    w_x    = r_sat ? INT32_MAX : 32'(w_t >>> 31);
    w_mask = (32'd1 << i_shift) - 32'd1;
    w_r    = w_x & w_mask;
    w_th   = (w_mask >> 1) + {31'd0, w_x[31]};
    w_sh   = w_x >>> i_shift;
    w_y    = w_sh + {31'd0, (w_r > w_th)};
    w_z    = {w_y[31], w_y} + {i_off[31], i_off};
    w_lo   = {{25{i_amin[7]}}, i_amin};
    w_hi   = {{25{i_amax[7]}}, i_amax};
    if (w_z < w_lo) w_z = w_lo;
    if (w_z > w_hi) w_z = w_hi;
    o_q    = w_z[7:0];
  end

endmodule

// File: rtl/c_drain_requant_seq.sv
// Drains C rows from gbuff_C, requantizes four lanes per row
// and queues packed int8 words in a credit-protected FIFO.
module c_drain_requant_seq
  import c_drain_requant_seq_pkg::*;
#(
  parameter int C_BITS    = 13,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [C_BITS-1:0] base_index,
  input  logic [C_BITS:0]   num_rows,
  input  logic [127:0]      bias,
  input  logic [31:0]       multiplier,
  input  logic [4:0]        shift,
  input  logic [31:0]       output_offset,
  input  logic [7:0]        act_min,
  input  logic [7:0]        act_max,
  output logic              c_own,
  output logic              c_rd_en,
  output logic [C_BITS-1:0] c_index,
  input  logic [127:0]      c_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);

  state_t            r_state;
  logic [C_BITS:0]   r_issued;
  logic [C_BITS:0]   r_rows;
  logic [C_BITS-1:0] r_base;
  logic [127:0]      r_bias;
  logic [31:0]       r_mult;
  logic [4:0]        r_shift;
  logic [31:0]       r_off;
  logic [7:0]        r_amin;
  logic [7:0]        r_amax;
  logic              r_done;
  logic              r_va;
  logic              r_vb;
  logic              r_vc;
  logic [31:0]       r_mem [OUT_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_cnt;

  logic [1:0]        w_infl;
  logic [CW:0]       w_occ;
  logic              w_rd;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_q [4];
  logic [31:0]       w_pack;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Each issued read reserves a FIFO slot until it is pushed.
  assign w_infl = {1'b0, r_va} + {1'b0, r_vb} + {1'b0, r_vc};
  assign w_occ  = {1'b0, r_cnt} + (CW + 1)'(w_infl);
  assign w_rd   = (r_state == RUN) && (r_issued < r_rows)
                  && (w_occ < (CW + 1)'(OUT_DEPTH));
  assign w_push = r_vc;
  assign w_pop  = out_valid && out_ready;

  assign c_own     = (r_state != IDLE);
  assign busy      = c_own;
  assign c_rd_en   = w_rd;
  assign c_index   = r_base + r_issued[C_BITS-1:0];
  assign done      = r_done;
  assign out_valid = (r_cnt != '0);
  assign out_data  = r_mem[r_rp];
  assign w_pack    = {w_q[0], w_q[1], w_q[2], w_q[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_issued <= '0;
      r_rows   <= '0;
      r_base   <= '0;
      r_bias   <= '0;
      r_mult   <= '0;
      r_shift  <= '0;
      r_off    <= '0;
      r_amin   <= '0;
      r_amax   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_base   <= base_index;
            r_rows   <= num_rows;
            r_bias   <= bias;
            r_mult   <= multiplier;
            r_shift  <= shift;
            r_off    <= output_offset;
            r_amin   <= act_min;
            r_amax   <= act_max;
            r_issued <= '0;
            r_state  <= (num_rows == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (w_rd) begin
            r_issued <= r_issued + 1'b1;
            if (r_issued == r_rows - 1'b1) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_infl == 2'd0 && r_cnt == '0) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_va  <= 1'b0;
      r_vb  <= 1'b0;
      r_vc  <= 1'b0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_va <= w_rd;
      r_vb <= r_va;
      r_vc <= r_vb;
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop)  r_rp <= f_inc(r_rp);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_pack;
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    requant_lane u_lane (
      .clk     (clk),
      .i_lane  (c_data[127-32*g -: 32]),
      .i_bias  (r_bias[127-32*g -: 32]),
      .i_mult  (r_mult),
      .i_shift (r_shift),
      .i_off   (r_off),
      .i_amin  (r_amin),
      .i_amax  (r_amax),
      .o_q     (w_q[g])
    );
  end

endmodule

// File: tb/tb_c_drain_requant_seq.sv
// Bench for c_drain_requant_seq: BRAM model, handshake monitor and
// an arithmetic reference for the requantized words.
module tb_c_drain_requant_seq;

  localparam int CB = 13;
  localparam int OD = 4;
  localparam longint MIN32 = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CB-1:0] base_index;
  logic [CB:0]   num_rows;
  logic [127:0]  bias;
  logic [31:0]   multiplier;
  logic [4:0]    shift;
  logic [31:0]   output_offset;
  logic [7:0]    act_min;
  logic [7:0]    act_max;
  logic          c_own;
  logic          c_rd_en;
  logic [CB-1:0] c_index;
  logic [127:0]  c_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;
  logic          done;

  c_drain_requant_seq #(.C_BITS(CB), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_index(base_index), .num_rows(num_rows),
    .bias(bias), .multiplier(multiplier), .shift(shift),
    .output_offset(output_offset),
    .act_min(act_min), .act_max(act_max),
    .c_own(c_own), .c_rd_en(c_rd_en), .c_index(c_index),
    .c_data(c_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [8192];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    c_data <= c_rd_en ? mem[c_index]
            : {$urandom, $urandom, $urandom, $urandom};
  end

  logic [CB-1:0] q_idx [$];
  logic [31:0]   q_out [$];
  int n_done, first_rd, first_ov, done_cyc, max_out, stab_bad;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (c_rd_en) begin
      q_idx.push_back(c_index);
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (prev_stall && out_data !== prev_data) stab_bad++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) q_out.push_back(out_data);
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (int'(q_idx.size()) - int'(q_out.size()) > max_out)
      max_out = int'(q_idx.size()) - int'(q_out.size());
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(
    input logic [31:0] lane, input logic [31:0] b,
    input logic [31:0] m, input logic [4:0] sh,
    input logic [31:0] off, input logic [7:0] lo,
    input logic [7:0] hi);
    longint acc, mm, p, x, mask, r, th, y, z;
    acc = longint'($signed(lane + b));
    mm  = longint'($signed(m));
    p   = acc * mm;
    if (acc == MIN32 && mm == MIN32) x = 64'sd2147483647;
    else x = (p + (p >= 0 ? 64'sd1073741824 : 64'sd1 - 64'sd1073741824))
             / 64'sd2147483648;
    mask = (64'sd1 <<< sh) - 1;
    r    = x & mask;
    th   = (mask >>> 1) + (x < 0 ? 1 : 0);
    y    = (x >>> sh) + (r > th ? 1 : 0);
    z    = y + longint'($signed(off));
    if (z < longint'($signed(lo))) z = longint'($signed(lo));
    if (z > longint'($signed(hi))) z = longint'($signed(hi));
    return z[7:0];
  endfunction

  logic [127:0] cfg_bias;
  logic [31:0]  cfg_mult;
  logic [4:0]   cfg_shift;
  logic [31:0]  cfg_off;
  logic [7:0]   cfg_min;
  logic [7:0]   cfg_max;

  function automatic logic [31:0] ref_word(input logic [127:0] row);
    logic [31:0] w;
    for (int l = 0; l < 4; l++)
      w[31-8*l -: 8] = ref_q(row[127-32*l -: 32], cfg_bias[127-32*l -: 32],
                             cfg_mult, cfg_shift, cfg_off, cfg_min, cfg_max);
    return w;
  endfunction

  task automatic clear_mon();
    q_idx.delete();
    q_out.delete();
    n_done = 0; first_rd = -1; first_ov = -1;
    done_cyc = -1; max_out = 0; stab_bad = 0;
  endtask

  task automatic scramble();
    base_index    = CB'($urandom);
    num_rows      = (CB + 1)'($urandom);
    bias          = {$urandom, $urandom, $urandom, $urandom};
    multiplier    = $urandom;
    shift         = 5'($urandom);
    output_offset = $urandom;
    act_min       = 8'($urandom);
    act_max       = 8'($urandom);
  endtask

  task automatic run_job(input string tag, input int base, input int rows,
                         input int hold, input bit poke);
    int s, idx;
    @(posedge clk); #1;
    clear_mon();
    base_index = base[CB-1:0]; num_rows = rows[CB:0];
    bias = cfg_bias; multiplier = cfg_mult; shift = cfg_shift;
    output_offset = cfg_off; act_min = cfg_min; act_max = cfg_max;
    out_ready = (hold == 0);
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    scramble();
    start = poke;
    if (poke) begin
      num_rows = '0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 400 && n_done == 0; k++) begin
      if (k + 1 >= hold) out_ready = 1'b1;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, ":done_cnt"}, n_done, 1);
    check({tag, ":busy_end"}, {31'd0, busy}, 0);
    check({tag, ":n_words"}, q_out.size(), rows);
    check({tag, ":n_reads"}, q_idx.size(), rows);
    check({tag, ":max_outst_ok"}, {31'd0, max_out <= OD}, 1);
    if (hold > 0) check({tag, ":stable"}, stab_bad, 0);
    if (rows == 0) check({tag, ":done_cyc"}, done_cyc, s + 2);
    else check({tag, ":first_rd"}, first_rd, s + 1);
    if (rows > 0 && hold == 0) check({tag, ":first_ov"}, first_ov, s + 5);
    for (int i = 0; i < rows; i++) begin
      idx = (base + i) % 8192;
      if (i < int'(q_idx.size()))
        check({tag, ":idx"}, 32'(q_idx[i]), idx);
      if (i < int'(q_out.size()))
        check({tag, ":word"}, q_out[i], ref_word(mem[idx]));
    end
  endtask

  task automatic rand_cfg();
    cfg_bias  = {$urandom, $urandom, $urandom, $urandom};
    cfg_mult  = $urandom;
    cfg_shift = 5'($urandom_range(0, 31));
    cfg_off   = 32'($urandom_range(0, 255)) - 32'd128;
    cfg_min   = 8'($urandom_range(0, 100)) - 8'd128;
    cfg_max   = 8'($urandom_range(0, 127));
  endtask

  task automatic plain_cfg();
    cfg_bias = '0; cfg_mult = 32'h4000_0000; cfg_shift = 5'd0;
    cfg_off = 32'd0; cfg_min = 8'h80; cfg_max = 8'h7F;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    scramble();
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst_c_own", {31'd0, c_own}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rd_en", {31'd0, c_rd_en}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_c_index", 32'(c_index), 0);
    reset = 1'b0;

    plain_cfg();
    for (int i = 0; i < 3; i++) mem[i] = {32'd100, 32'd200, -32'sd50, 32'd0};
    run_job("basic", 0, 3, 0, 1'b0);
    check("basic_w0", q_out[0], 32'h3264E700);

    plain_cfg();
    cfg_shift = 5'd1; cfg_off = -32'sd128;
    mem[5] = {32'd1000, 32'd7, -32'sd9000, 32'd3};
    run_job("shift1", 5, 1, 0, 1'b0);
    check("shift1_lane0", {24'd0, q_out[0][31:24]}, 32'h7A);

    plain_cfg();
    run_job("clamp", 5, 1, 0, 1'b0);
    check("clamp_lane0", {24'd0, q_out[0][31:24]}, 32'h7F);

    plain_cfg();
    cfg_mult = 32'h8000_0000; cfg_shift = 5'd31;
    mem[9] = {32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd12345};
    run_job("minmin", 9, 1, 0, 1'b0);
    check("minmin_lane0", {24'd0, q_out[0][31:24]}, 32'h01);

    rand_cfg();
    run_job("backpr", 100, 10, 20, 1'b1);
    check("backpr_full", max_out, OD);

    rand_cfg();
    run_job("wrap", 8190, 4, 0, 1'b0);

    rand_cfg();
    run_job("zero", 77, 0, 0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      rand_cfg();
      run_job("rand", int'($urandom_range(0, 8191)),
              int'($urandom_range(1, 8)), int'($urandom_range(0, 6)), 1'b0);
    end

    rand_cfg();
    @(posedge clk); #1;
    clear_mon();
    base_index = 13'd300; num_rows = 14'd10; out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_own", {31'd0, c_own}, 0);
    check("mid_rst_ov", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_done", n_done, 0);
    check("mid_rst_words", q_out.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
